// File: rtl/level_sequencer.sv
// level_sequencer
// Game-flow controller. Owns the current level number and the lives count,
// and steps the game through IDLE, BANNER, PLAY, PAUSE, CLEARED, HIT,
// GAME_OVER and WIN. All phase timing is counted in video frames.
//
// Ports:
//   clk             system clock
//   resetN          asynchronous active-low reset
//   startOfFrame    one-cycle pulse per video frame
//   startGame       one-cycle key pulse (honoured in IDLE, GAME_OVER, WIN)
//   pauseKey        one-cycle key pulse (PLAY <-> PAUSE)
//   allBallsCleared one-cycle pulse from the ball manager
//   playerHit       one-cycle pulse from collision logic
//   levelState      current level, 1..MAX_LEVEL
//   lives           remaining lives
//   gameState       encoded phase (IDLE=0 .. WIN=7)
//   playEnable      high only in PLAY
//   loadLevel       one-cycle pulse on the first cycle of PLAY after BANNER
//   levelVisible    visibility for the level digit display (blinks in BANNER)
module level_sequencer #(
  parameter int unsigned MAX_LEVEL     = 12,
  parameter int unsigned START_LIVES   = 3,
  parameter int unsigned BANNER_FRAMES = 120,
  parameter int unsigned CLEAR_FRAMES  = 90,
  parameter int unsigned HIT_FRAMES    = 60,
  parameter int unsigned BLINK_LOG2    = 4
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       startGame,
  input  logic       pauseKey,
  input  logic       allBallsCleared,
  input  logic       playerHit,
  output logic [3:0] levelState,
  output logic [2:0] lives,
  output logic [2:0] gameState,
  output logic       playEnable,
  output logic       loadLevel,
  output logic       levelVisible
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_BANNER    = 3'd1,
    ST_PLAY      = 3'd2,
    ST_PAUSE     = 3'd3,
    ST_CLEARED   = 3'd4,
    ST_HIT       = 3'd5,
    ST_GAME_OVER = 3'd6,
    ST_WIN       = 3'd7
  } state_t;

  // Last frame index of each timed phase: the phase exits on the frame pulse
  // that arrives while the counter holds this value.
  localparam logic [7:0] BANNER_LAST = 8'(BANNER_FRAMES - 1);
  localparam logic [7:0] CLEAR_LAST  = 8'(CLEAR_FRAMES - 1);
  localparam logic [7:0] HIT_LAST    = 8'(HIT_FRAMES - 1);
  localparam logic [3:0] LEVEL_MAX   = 4'(MAX_LEVEL);
  localparam logic [2:0] LIVES_INIT  = 3'(START_LIVES);

  state_t     state_r;
  state_t     state_s;
  logic [7:0] frame_cnt_r;
  logic [7:0] frame_cnt_s;
  logic [3:0] level_s;
  logic [2:0] lives_s;
  logic       load_s;
  logic       visible_s;

  // Next-state, counter, level/lives and output decode.
  always_comb begin
    state_s   = state_r;
    level_s   = levelState;
    lives_s   = lives;
    load_s    = 1'b0;
    visible_s = 1'b0;

    case (state_r)
      ST_IDLE, ST_GAME_OVER, ST_WIN: begin
        if (startGame) begin
          state_s = ST_BANNER;
          level_s = 4'd1;
          lives_s = LIVES_INIT;
        end else begin
          state_s = state_r;
        end
      end
      ST_BANNER: begin
        if (startOfFrame && (frame_cnt_r == BANNER_LAST)) begin
          state_s = ST_PLAY;
          load_s  = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      ST_PLAY: begin
        // Clear beats hit beats pause when pulses coincide.
        if (allBallsCleared) begin
          state_s = ST_CLEARED;
        end else if (playerHit) begin
          state_s = ST_HIT;
          lives_s = (lives != 3'd0) ? (lives - 3'd1) : 3'd0;
        end else if (pauseKey) begin
          state_s = ST_PAUSE;
        end else begin
          state_s = state_r;
        end
      end
      ST_PAUSE: begin
        if (pauseKey) begin
          state_s = ST_PLAY;
        end else begin
          state_s = state_r;
        end
      end
      ST_CLEARED: begin
        if (startOfFrame && (frame_cnt_r == CLEAR_LAST)) begin
          if (levelState >= LEVEL_MAX) begin
            state_s = ST_WIN;
          end else begin
            state_s = ST_BANNER;
            level_s = levelState + 4'd1;
          end
        end else begin
          state_s = state_r;
        end
      end
      ST_HIT: begin
        if (startOfFrame && (frame_cnt_r == HIT_LAST)) begin
          if (lives == 3'd0) begin
            state_s = ST_GAME_OVER;
          end else begin
            state_s = ST_BANNER;
          end
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // A phase change restarts the frame count; PAUSE freezes it.
    if (state_s != state_r) begin
      frame_cnt_s = 8'd0;
    end else if (startOfFrame && (state_r != ST_PAUSE)) begin
      frame_cnt_s = frame_cnt_r + 8'd1;
    end else begin
      frame_cnt_s = frame_cnt_r;
    end

    case (state_s)
      ST_BANNER:                         visible_s = ~frame_cnt_s[BLINK_LOG2];
      ST_PLAY, ST_PAUSE, ST_CLEARED, ST_HIT: visible_s = 1'b1;
      default:                           visible_s = 1'b0;
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r      <= ST_IDLE;
      frame_cnt_r  <= 8'd0;
      levelState   <= 4'd1;
      lives        <= LIVES_INIT;
      playEnable   <= 1'b0;
      loadLevel    <= 1'b0;
      levelVisible <= 1'b0;
    end else begin
      state_r      <= state_s;
      frame_cnt_r  <= frame_cnt_s;
      levelState   <= level_s;
      lives        <= lives_s;
      playEnable   <= (state_s == ST_PLAY);
      loadLevel    <= load_s;
      levelVisible <= visible_s;
    end
  end

  assign gameState = state_r;

endmodule

// File: tb/tb_level_sequencer.sv
// Testbench for level_sequencer: directed game scenarios plus a random
// phase, checked cycle by cycle against a phase/frames-remaining model.
module tb_level_sequencer;

  localparam int MAXL = 12;
  localparam int SL   = 3;
  localparam int BF   = 120;
  localparam int CF   = 90;
  localparam int HF   = 60;
  localparam int BL   = 4;

  logic       clk = 1'b0;
  logic       resetN;
  logic       sof, sg, pk, abc, ph;
  logic [3:0] levelState;
  logic [2:0] lives;
  logic [2:0] gameState;
  logic       playEnable, loadLevel, levelVisible;

  always #5 clk = ~clk;

  level_sequencer #(
    .MAX_LEVEL(MAXL), .START_LIVES(SL), .BANNER_FRAMES(BF),
    .CLEAR_FRAMES(CF), .HIT_FRAMES(HF), .BLINK_LOG2(BL)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .startGame(sg),
    .pauseKey(pk), .allBallsCleared(abc), .playerHit(ph),
    .levelState(levelState), .lives(lives), .gameState(gameState),
    .playEnable(playEnable), .loadLevel(loadLevel), .levelVisible(levelVisible)
  );

  typedef struct packed {
    logic [2:0] gs;
    logic [3:0] lvl;
    logic [2:0] lv;
    logic       pe;
    logic       ld;
    logic       vis;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   rst_req  = 1'b0;

  // Reference model: phase, level, lives, frames still to wait in a timed phase.
  int m_state, m_level, m_lives, m_left;
  bit m_load;

  function automatic void model_reset();
    m_state = 0; m_level = 1; m_lives = SL; m_left = 0; m_load = 1'b0;
  endfunction

  function automatic void enter_banner();
    m_state = 1; m_left = BF;
  endfunction

  function automatic void model_step(bit f, bit s, bit p, bit a, bit h);
    m_load = 1'b0;
    case (m_state)
      0, 6, 7: if (s) begin m_level = 1; m_lives = SL; enter_banner(); end
      1: if (f) begin
           m_left--;
           if (m_left == 0) begin m_state = 2; m_load = 1'b1; end
         end
      2: if (a) begin m_state = 4; m_left = CF; end
         else if (h) begin m_state = 5; m_lives--; m_left = HF; end
         else if (p) m_state = 3;
      3: if (p) m_state = 2;
      4: if (f) begin
           m_left--;
           if (m_left == 0) begin
             if (m_level == MAXL) m_state = 7;
             else begin m_level++; enter_banner(); end
           end
         end
      5: if (f) begin
           m_left--;
           if (m_left == 0) begin
             if (m_lives == 0) m_state = 6;
             else enter_banner();
           end
         end
      default: ;
    endcase
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    int   elapsed;
    e.gs  = 3'(m_state);
    e.lvl = 4'(m_level);
    e.lv  = 3'(m_lives);
    e.pe  = (m_state == 2);
    e.ld  = m_load;
    case (m_state)
      1: begin
        elapsed = BF - m_left;
        e.vis = ((elapsed / (1 << BL)) % 2) == 0;
      end
      2, 3, 4, 5: e.vis = 1'b1;
      default:    e.vis = 1'b0;
    endcase
    return e;
  endfunction

  // Drive one cycle of inputs at the falling edge and queue the expected outputs.
  task automatic tick(bit f, bit s, bit p, bit a, bit h);
    @(negedge clk);
    resetN = rst_req;
    sof = f; sg = s; pk = p; abc = a; ph = h;
    if (!rst_req) model_reset();
    else model_step(f, s, p, a, h);
    exp_q.push_back(model_out());
  endtask

  // Random ignored-input noise, only in phases where those inputs must do nothing.
  function automatic bit nz();
    return ((m_state == 1) || (m_state == 4) || (m_state == 5)) && ($urandom_range(0, 7) == 0);
  endfunction

  task automatic run_frames(int n);
    for (int i = 0; i < n; i++) begin
      tick(1'b1, nz(), nz(), nz(), nz());
      tick(1'b0, nz(), nz(), nz(), nz());
    end
  endtask

  // Assert reset between edges and check outputs before any clock edge.
  task automatic mid_reset();
    @(negedge clk);
    #2;
    rst_req = 1'b0;
    resetN = 1'b0;
    sof = 1'b0; sg = 1'b0; pk = 1'b0; abc = 1'b0; ph = 1'b0;
    #1;
    n_checks++;
    if (gameState !== 3'd0 || levelState !== 4'd1 || lives !== 3'(SL) ||
        playEnable !== 1'b0 || loadLevel !== 1'b0 || levelVisible !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset: got gs=%0d lvl=%0d lives=%0d pe=%0b ld=%0b vis=%0b, expected gs=0 lvl=1 lives=%0d pe=0 ld=0 vis=0",
               gameState, levelState, lives, playEnable, loadLevel, levelVisible, SL);
    end
    model_reset();
    exp_q.push_back(model_out());
  endtask

  // Monitor: every cycle the DUT presents outputs, compare against the queue head.
  always @(posedge clk) begin : monitor
    exp_t e;
    exp_t a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {gameState, levelState, lives, playEnable, loadLevel, levelVisible};
      n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL cycle_outputs t=%0t: got gs=%0d lvl=%0d lives=%0d pe=%0b ld=%0b vis=%0b, expected gs=%0d lvl=%0d lives=%0d pe=%0b ld=%0b vis=%0b",
                 $time, a.gs, a.lvl, a.lv, a.pe, a.ld, a.vis, e.gs, e.lvl, e.lv, e.pe, e.ld, e.vis);
      end
    end
  end

  initial begin
    resetN = 1'b0;
    sof = 1'b0; sg = 1'b0; pk = 1'b0; abc = 1'b0; ph = 1'b0;
    model_reset();

    repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_req = 1'b1;

    // IDLE ignores everything but startGame.
    repeat (6) tick(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // Start and banner timing.
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_frames(BF);
    repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Level progression to WIN, with a pause test on level 3.
    for (int l = 1; l <= MAXL; l++) begin
      if (l == 3) begin
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      tick(l == 5, 1'b0, 1'b0, 1'b1, 1'b0);
      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_frames(CF);
      if (l < MAXL) run_frames(BF);
    end
    tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Restart from WIN, then coincident clear and hit.
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_frames(BF);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    run_frames(CF);
    run_frames(BF);

    // Death sequence.
    for (int k = 0; k < SL; k++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      run_frames(HF);
      if (m_lives > 0) run_frames(BF);
    end
    tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    run_frames(BF);

    // Advance to level 7, enter CLEARED, reset mid-phase.
    while (m_level < 7) begin
      tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      run_frames(CF);
      run_frames(BF);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_frames(10);
    mid_reset();
    repeat (2) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_req = 1'b1;
    repeat (2) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Random phase.
    repeat (4000)
      tick(1'($urandom_range(0, 1)), $urandom_range(0, 31) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 63) == 0, $urandom_range(0, 63) == 0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
